// File: rtl/param_interrupt_request_register_pkg.sv
// Shared constants and helpers for the parametrised 8259A interrupt request register.
package param_interrupt_request_register_pkg;

  localparam int PIC_NUM_IR_DEFAULT      = 8;
  localparam int PIC_SYNC_STAGES_DEFAULT = 2;

  localparam logic LTIM_EDGE  = 1'b0;
  localparam logic LTIM_LEVEL = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_interrupt_request_register_if.sv
// Request/mask/acknowledge bundle between the PIC control logic and the IRR block.
interface param_interrupt_request_register_if
  import param_interrupt_request_register_pkg::*;
#(
  parameter int NUM_IR = PIC_NUM_IR_DEFAULT,
  parameter int IDX_W  = idx_width(NUM_IR)
) ();

  logic [NUM_IR-1:0] IR_in;
  logic              levelTriggered;
  logic [NUM_IR-1:0] bitToMask;
  logic              freeze;
  logic              ackValid;
  logic [IDX_W-1:0]  ackIndex;
  logic              readIRR;
  logic [NUM_IR-1:0] risedBits;
  logic [NUM_IR-1:0] dataBuffer;
  logic              pendingAny;

  modport master (
    output IR_in, levelTriggered, bitToMask, freeze, ackValid, ackIndex, readIRR,
    input  risedBits, dataBuffer, pendingAny
  );

  modport slave (
    input  IR_in, levelTriggered, bitToMask, freeze, ackValid, ackIndex, readIRR,
    output risedBits, dataBuffer, pendingAny
  );

endinterface

// File: rtl/param_interrupt_request_register_irr_channel.sv
// One IRR bit cell: previous-sample flop, edge-held flop during freeze and the request bit.
module param_interrupt_request_register_irr_channel
  import param_interrupt_request_register_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic level,
  input  logic freeze,
  input  logic mode_change,
  input  logic ack,
  output logic irr_bit
);

  logic ir_prev;
  logic edge_held;
  logic rise;

  assign rise = sample & ~ir_prev;

  // Acknowledge always wins over any same-cycle set source for this bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_prev   <= 1'b0;
      edge_held <= 1'b0;
      irr_bit   <= 1'b0;
    end else begin
      ir_prev <= sample;
      if (mode_change) begin
        irr_bit   <= 1'b0;
        edge_held <= 1'b0;
      end else if (level == LTIM_LEVEL) begin
        edge_held <= 1'b0;
        irr_bit   <= ~ack & (freeze ? irr_bit : sample);
      end else if (freeze) begin
        edge_held <= ~ack & (edge_held | rise);
        irr_bit   <= ~ack & irr_bit;
      end else begin
        edge_held <= 1'b0;
        irr_bit   <= ~ack & (irr_bit | rise | edge_held);
      end
    end
  end

endmodule

// File: rtl/param_interrupt_request_register.sv
// 8259A interrupt request register, NUM_IR channels, edge or level capture.
// Optional input synchronizer enabled by defining IRR_SYNC_EN.
module param_interrupt_request_register
  import param_interrupt_request_register_pkg::*;
#(
  parameter int NUM_IR      = PIC_NUM_IR_DEFAULT,
  parameter int SYNC_STAGES = PIC_SYNC_STAGES_DEFAULT
) (
  input logic clk,
  input logic reset,
  param_interrupt_request_register_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_IR);

  if (NUM_IR < 2 || NUM_IR > 32 || SYNC_STAGES < 2) begin : g_param_check
    $error("param_interrupt_request_register: NUM_IR must be 2..32 and SYNC_STAGES >= 2");
  end

  logic [NUM_IR-1:0] ir_sample;
  logic [NUM_IR-1:0] irr;
  logic [NUM_IR-1:0] ack_hit;
  logic              lt_q;
  logic              mode_change;

`ifdef IRR_SYNC_EN
  logic [NUM_IR-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.IR_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign ir_sample = sync_q[SYNC_STAGES-1];
`else
  assign ir_sample = bus.IR_in;
`endif

  // A change of trigger mode flushes all pending requests for one cycle.
  always_ff @(posedge clk) begin
    if (reset) lt_q <= LTIM_EDGE;
    else       lt_q <= bus.levelTriggered;
  end

  assign mode_change = (bus.levelTriggered != lt_q);

  // Out-of-range indices match no channel and are therefore ignored.
  always_comb begin
    ack_hit = '0;
    for (int n = 0; n < NUM_IR; n++) begin
      ack_hit[n] = bus.ackValid && (bus.ackIndex == IDX_W'(n));
    end
  end

  for (genvar n = 0; n < NUM_IR; n++) begin : g_chan
    param_interrupt_request_register_irr_channel u_chan (
      .clk         (clk),
      .reset       (reset),
      .sample      (ir_sample[n]),
      .level       (bus.levelTriggered),
      .freeze      (bus.freeze),
      .mode_change (mode_change),
      .ack         (ack_hit[n]),
      .irr_bit     (irr[n])
    );
  end

  assign bus.risedBits  = irr & ~bus.bitToMask;
  assign bus.pendingAny = |bus.risedBits;

  always_ff @(posedge clk) begin
    if (reset) bus.dataBuffer <= '0;
    else       bus.dataBuffer <= bus.readIRR ? irr : '0;
  end

endmodule

// File: tb/tb_param_interrupt_request_register.sv
// Directed bench for the IRR: an 8-channel instance plus a 6-channel one for out-of-range acks.
module tb_param_interrupt_request_register;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  param_interrupt_request_register_if #(.NUM_IR(8)) bus8 ();
  param_interrupt_request_register_if #(.NUM_IR(6)) bus6 ();

  param_interrupt_request_register #(.NUM_IR(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  param_interrupt_request_register #(.NUM_IR(6)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus8.IR_in = '0; bus8.levelTriggered = 1'b0; bus8.bitToMask = '0; bus8.freeze = 1'b0;
    bus8.ackValid = 1'b0; bus8.ackIndex = '0; bus8.readIRR = 1'b0;
    bus6.IR_in = '0; bus6.levelTriggered = 1'b0; bus6.bitToMask = '0; bus6.freeze = 1'b0;
    bus6.ackValid = 1'b0; bus6.ackIndex = '0; bus6.readIRR = 1'b0;
    step();
    step();
    chk("reset_rised", bus8.risedBits, 32'h00);
    chk("reset_pending", bus8.pendingAny, 32'h0);
    chk("reset_databuf", bus8.dataBuffer, 32'h00);
    chk("reset_rised6", bus6.risedBits, 32'h00);

    reset = 1'b0;
    bus6.IR_in = 6'h3F;
    step();
    chk("n6_capture", bus6.risedBits, 32'h3F);
    bus6.ackValid = 1'b1; bus6.ackIndex = 3'd7;
    step();
    chk("n6_ack_out_of_range", bus6.risedBits, 32'h3F);
    bus6.ackIndex = 3'd5;
    step();
    chk("n6_ack_idx5", bus6.risedBits, 32'h1F);
    bus6.ackValid = 1'b0;

    bus8.IR_in = 8'h04;
    step();
    chk("edge_capture", bus8.risedBits, 32'h04);
    chk("edge_pending", bus8.pendingAny, 32'h1);
    bus8.ackValid = 1'b1; bus8.ackIndex = 3'd2;
    step();
    chk("edge_ack_clear", bus8.risedBits, 32'h00);
    bus8.ackValid = 1'b0;
    step();
    chk("edge_no_retrigger", bus8.risedBits, 32'h00);
    chk("edge_no_pending", bus8.pendingAny, 32'h0);

    bus8.levelTriggered = 1'b1; bus8.IR_in = 8'h81;
    step();
    chk("level_mode_flush", bus8.risedBits, 32'h00);
    step();
    chk("level_track_81", bus8.risedBits, 32'h81);
    bus8.IR_in = 8'h01;
    step();
    chk("level_drop_to_01", bus8.risedBits, 32'h01);
    bus8.ackValid = 1'b1; bus8.ackIndex = 3'd0;
    step();
    chk("level_ack_clear", bus8.risedBits, 32'h00);
    bus8.ackValid = 1'b0;
    step();
    chk("level_reassert", bus8.risedBits, 32'h01);

    bus8.levelTriggered = 1'b0; bus8.IR_in = 8'h00;
    step();
    chk("back_to_edge_flush", bus8.risedBits, 32'h00);
    bus8.IR_in = 8'h02;
    step();
    chk("freeze_setup", bus8.risedBits, 32'h02);
    bus8.freeze = 1'b1; bus8.IR_in = 8'h22;
    step();
    chk("freeze_hold_1", bus8.risedBits, 32'h02);
    step();
    chk("freeze_hold_2", bus8.risedBits, 32'h02);
    bus8.freeze = 1'b0;
    step();
    chk("freeze_release", bus8.risedBits, 32'h22);

    bus8.ackValid = 1'b1; bus8.ackIndex = 3'd1;
    step();
    chk("ack_idx1", bus8.risedBits, 32'h20);
    bus8.ackIndex = 3'd5;
    step();
    chk("ack_idx5", bus8.risedBits, 32'h00);
    bus8.ackValid = 1'b0;
    bus8.IR_in = 8'h2A;
    step();
    chk("rise_bit3", bus8.risedBits, 32'h08);
    bus8.IR_in = 8'h02;
    step();
    chk("edge_latched_after_drop", bus8.risedBits, 32'h08);
    bus8.IR_in = 8'h4A; bus8.ackValid = 1'b1; bus8.ackIndex = 3'd3;
    step();
    chk("ack_beats_rise", bus8.risedBits, 32'h40);
    bus8.ackValid = 1'b0;

    bus8.IR_in = 8'hF0;
    step();
    chk("irr_F0", bus8.risedBits, 32'hF0);
    bus8.bitToMask = 8'hC0;
    #1;
    chk("mask_C0", bus8.risedBits, 32'h30);
    chk("mask_pending", bus8.pendingAny, 32'h1);
    bus8.readIRR = 1'b1;
    step();
    chk("read_irr_F0", bus8.dataBuffer, 32'hF0);
    bus8.readIRR = 1'b0;
    step();
    chk("read_off", bus8.dataBuffer, 32'h00);
    bus8.bitToMask = 8'h00;
    #1;
    chk("unmask_same_cycle", bus8.risedBits, 32'hF0);

    bus8.levelTriggered = 1'b1;
    step();
    bus8.levelTriggered = 1'b0; bus8.IR_in = 8'h00;
    step();
    chk("mode_flush_twice", bus8.risedBits, 32'h00);
    bus8.IR_in = 8'h0F;
    step();
    chk("irr_0F", bus8.risedBits, 32'h0F);
    bus8.levelTriggered = 1'b1;
    step();
    chk("mode_switch_clears", bus8.risedBits, 32'h00);
    step();
    chk("level_after_switch", bus8.risedBits, 32'h0F);
    bus8.freeze = 1'b1; bus8.readIRR = 1'b1;
    step();
    chk("frozen_readback", bus8.dataBuffer, 32'h0F);
    reset = 1'b1; bus8.ackValid = 1'b1; bus8.ackIndex = 3'd0;
    step();
    chk("reset_mid_freeze_rised", bus8.risedBits, 32'h00);
    chk("reset_mid_freeze_pending", bus8.pendingAny, 32'h0);
    chk("reset_mid_freeze_databuf", bus8.dataBuffer, 32'h00);

    reset = 1'b0; bus8.freeze = 1'b0; bus8.ackValid = 1'b0; bus8.readIRR = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
